arbitro_memoria: RTL and testbench

//  Shares the single unified memory port between instruction fetch (driven by the UC fetch state) and

---
 rtl/arbitro_memoria_pkg.sv | 27 ++
 rtl/arbitro_memoria_contador_latencia.sv | 27 ++
 rtl/arbitro_memoria.sv | 132 +++++++++++++
 tb/tb_arbitro_memoria.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_memoria_pkg.sv
// Shared types for the unified-memory arbiter: FSM state codes, grant ids
// and the fetch/data winner selection used in the idle state.
package arbitro_memoria_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EMITE    = 2'd1,
    ESPERA   = 2'd2,
    RESPONDE = 2'd3
  } estado_t;

  typedef enum logic {
    G_BUSCA = 1'b0,
    G_DADO  = 1'b1
  } grant_t;

  localparam int LAT_W = 4;

  // Data has priority unless fetch is being starved and is also requesting.
  function automatic grant_t escolhe_grant(input logic if_req, input logic d_req,
                                           input logic forca_busca);
    if (d_req && !(if_req && forca_busca))
      return G_DADO;
    return G_BUSCA;
  endfunction

endpackage

// File: rtl/arbitro_memoria_contador_latencia.sv
// Memory read latency timer: loads MEM_LAT-1 when the strobe is issued and
// counts down while waiting; zero marks the cycle mem_rdata is valid.
module contador_latencia
  import arbitro_memoria_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             carga,
  input  logic             decr,
  input  logic [LAT_W-1:0] valor,
  output logic             zero
);

  logic [LAT_W-1:0] conta;

  always_ff @(posedge clk) begin
    if (reset)
      conta <= '0;
    else if (carga)
      conta <= valor;
    else if (decr && (conta != '0))
      conta <= conta - 1'b1;
  end

  assign zero = (conta == '0);

endmodule

// File: rtl/arbitro_memoria.sv
// Arbiter sharing one memory port between instruction fetch and data
// load/store; one transaction in flight, fixed read latency, registered acks.
//
//  state    | meaning
//  OCIOSO   | idle, arbitrate and latch the winning request
//  EMITE    | one-cycle mem_en strobe, latency timer loaded
//  ESPERA   | timer running, read data captured when it hits zero
//  RESPONDE | one-cycle ack pulse to the granted requester
module arbitro_memoria
  import arbitro_memoria_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int FAIR_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int               SW        = $clog2(FAIR_LIMIT + 1);
  localparam logic [SW-1:0]    STREAK_MX = SW'(FAIR_LIMIT);
  localparam logic [LAT_W-1:0] LAT_CARGA = LAT_W'(MEM_LAT - 1);

  estado_t       estado;
  grant_t        grant;
  logic          we_lat;
  logic [SW-1:0] streak;
  logic          lat_zero;
  logic          lat_carga;
  logic          lat_decr;

  assign lat_carga = (estado == EMITE);
  assign lat_decr  = (estado == ESPERA);

  contador_latencia u_lat (
    .clk   (clk),
    .reset (reset),
    .carga (lat_carga),
    .decr  (lat_decr),
    .valor (LAT_CARGA),
    .zero  (lat_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado    <= OCIOSO;
      grant     <= G_BUSCA;
      we_lat    <= 1'b0;
      streak    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (if_req || d_req) begin
            if (escolhe_grant(if_req, d_req, streak == STREAK_MX) == G_DADO) begin
              grant     <= G_DADO;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              we_lat    <= d_we;
              mem_we    <= d_we;
              // Only data grants that actually made fetch wait count towards fairness.
              if (if_req && (streak != STREAK_MX))
                streak <= streak + 1'b1;
            end else begin
              grant    <= G_BUSCA;
              mem_addr <= if_addr;
              we_lat   <= 1'b0;
              streak   <= '0;
            end
            mem_en <= 1'b1;
            busy   <= 1'b1;
            estado <= EMITE;
          end
        end
        EMITE: begin
          estado <= ESPERA;
        end
        ESPERA: begin
          if (lat_zero) begin
            if (grant == G_DADO) begin
              if (!we_lat)
                d_rdata <= mem_rdata;
              d_ack <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
            estado <= RESPONDE;
          end
        end
        RESPONDE: begin
          busy   <= 1'b0;
          estado <= OCIOSO;
        end
        default: begin
          busy   <= 1'b0;
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria: three instances (MEM_LAT 2, 1, 15)
// against a latency-exact memory model with hand-computed expectations.
module tb_arbitro_memoria;

  localparam int N = 3;
  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        if_req    [N];
  logic [63:0] if_addr   [N];
  logic        if_ack    [N];
  logic [63:0] if_rdata  [N];
  logic        d_req     [N];
  logic        d_we      [N];
  logic [63:0] d_addr    [N];
  logic [63:0] d_wdata   [N];
  logic        d_ack     [N];
  logic [63:0] d_rdata   [N];
  logic        mem_en    [N];
  logic        mem_we    [N];
  logic [63:0] mem_addr  [N];
  logic [63:0] mem_wdata [N];
  logic [63:0] mem_rdata [N];
  logic        busy      [N];

  function automatic int lat_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h40)
      return 64'h0000_0000_0050_0093;
    return {32'hC0DE_0000, a[31:0]};
  endfunction

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      arbitro_memoria #(
        .ADDR_W(64), .DATA_W(64), .MEM_LAT(lat_of(g)), .FAIR_LIMIT(4)
      ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req[g]),
        .if_addr   (if_addr[g]),
        .if_ack    (if_ack[g]),
        .if_rdata  (if_rdata[g]),
        .d_req     (d_req[g]),
        .d_we      (d_we[g]),
        .d_addr    (d_addr[g]),
        .d_wdata   (d_wdata[g]),
        .d_ack     (d_ack[g]),
        .d_rdata   (d_rdata[g]),
        .mem_en    (mem_en[g]),
        .mem_we    (mem_we[g]),
        .mem_addr  (mem_addr[g]),
        .mem_wdata (mem_wdata[g]),
        .mem_rdata (mem_rdata[g]),
        .busy      (busy[g])
      );
    end
  endgenerate

  // Memory model: read data valid only in the single cycle MEM_LAT after mem_en.
  int cyc = 0;
  int mcnt [N] = '{default: 0};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < N; k++) begin
      if (mem_en[k])
        mcnt[k] <= 1;
      else if (mcnt[k] != 0 && mcnt[k] < 31)
        mcnt[k] <= mcnt[k] + 1;
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      mem_rdata[k] = JUNK;
      if (mcnt[k] == lat_of(k))
        mem_rdata[k] = mem_word(mem_addr[k]);
    end
  end

  int          en_cnt     [N] = '{default: 0};
  int          en_cyc     [N] = '{default: 0};
  int          if_ack_cnt [N] = '{default: 0};
  int          d_ack_cnt  [N] = '{default: 0};
  logic        prev_en    [N] = '{default: 1'b0};
  logic        en_we      [N] = '{default: 1'b0};
  logic [63:0] en_wdata   [N] = '{default: 64'h0};
  logic [63:0] en_addr    [N] = '{default: 64'h0};
  logic [31:0] glog = 32'h0;
  int          wide_viol = 0;
  int          we_viol = 0;

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (mem_en[k]) begin
        en_cnt[k]   <= en_cnt[k] + 1;
        en_cyc[k]   <= cyc;
        en_we[k]    <= mem_we[k];
        en_wdata[k] <= mem_wdata[k];
        en_addr[k]  <= mem_addr[k];
        if (k == 0)
          glog <= {glog[30:0], (mem_addr[k] >= 64'h100)};
      end
      if (mem_en[k] && prev_en[k])
        wide_viol <= wide_viol + 1;
      if (mem_we[k] && !mem_en[k])
        we_viol <= we_viol + 1;
      if (if_ack[k])
        if_ack_cnt[k] <= if_ack_cnt[k] + 1;
      if (d_ack[k])
        d_ack_cnt[k] <= d_ack_cnt[k] + 1;
      prev_en[k] <= mem_en[k];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on instance k from an idle cycle; returns request and ack cycles.
  task automatic run_txn(input int k, input logic dado, input logic we,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         output int t, output int ack_c);
    ack_c = -1;
    t = cyc;
    if (dado) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if ((dado ? d_ack[k] : if_ack[k]) === 1'b1) begin
        ack_c = cyc;
        break;
      end
    end
    if (dado) d_req[k] = 1'b0;
    else      if_req[k] = 1'b0;
    tick();
  endtask

  initial begin
    int t, a, ad, af, nd, e0, n0;
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    repeat (3) tick();
    check_eq("rst_mem_en", 64'(mem_en[0]), 0);
    check_eq("rst_busy", 64'(busy[0]), 0);
    check_eq("rst_acks", 64'({if_ack[0], d_ack[0]}), 0);
    check_eq("rst_if_rdata", if_rdata[0], 0);
    check_eq("rst_d_rdata", d_rdata[0], 0);
    check_eq("rst_mem_addr", mem_addr[0], 0);
    reset = 1'b0;
    tick();

    // fetch only
    e0 = en_cnt[0]; n0 = d_ack_cnt[0];
    run_txn(0, 1'b0, 1'b0, 64'h40, 64'h0, t, a);
    check_eq("f_ack_lat", 64'(a - t), 4);
    check_eq("f_en_cyc", 64'(en_cyc[0] - t), 1);
    check_eq("f_en_cnt", 64'(en_cnt[0] - e0), 1);
    check_eq("f_rdata", if_rdata[0], 64'h0000_0000_0050_0093);
    check_eq("f_no_dack", 64'(d_ack_cnt[0] - n0), 0);

    // simultaneous requests: data first, then fetch
    t = cyc; ad = -1; af = -1;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 64'h100;
    if_req[0] = 1'b1; if_addr[0] = 64'h44;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (d_ack[0] === 1'b1) begin ad = cyc; d_req[0] = 1'b0; end
      if (if_ack[0] === 1'b1) begin af = cyc; if_req[0] = 1'b0; end
      if (ad >= 0 && af >= 0) break;
    end
    tick();
    check_eq("s_d_lat", 64'(ad - t), 4);
    check_eq("s_f_lat", 64'(af - t), 9);
    check_eq("s_d_rdata", d_rdata[0], 64'hC0DE_0000_0000_0100);
    check_eq("s_f_rdata", if_rdata[0], 64'hC0DE_0000_0000_0044);
    check_eq("s_order", 64'(glog[1:0]), 64'b10);

    // fairness: four data grants then forced fetch
    t = cyc; nd = 0; af = -1;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 64'h100;
    if_req[0] = 1'b1; if_addr[0] = 64'h4C;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (d_ack[0] === 1'b1) begin nd++; d_addr[0] = d_addr[0] + 64'h8; end
      if (if_ack[0] === 1'b1) begin af = cyc; if_req[0] = 1'b0; break; end
    end
    check_eq("fair_dacks", 64'(nd), 4);
    check_eq("fair_f_lat", 64'(af - t), 24);
    check_eq("fair_order", 64'(glog[4:0]), 64'b11110);
    ad = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (d_ack[0] === 1'b1) begin ad = cyc; d_req[0] = 1'b0; break; end
    end
    tick();
    check_eq("fair_d6_lat", 64'(ad - t), 29);
    check_eq("fair_d6_rdata", d_rdata[0], 64'hC0DE_0000_0000_0120);

    // store
    e0 = en_cnt[0];
    run_txn(0, 1'b1, 1'b1, 64'h200, 64'h0000_0000_DEAD_BEEF, t, a);
    check_eq("st_ack_lat", 64'(a - t), 4);
    check_eq("st_en_cnt", 64'(en_cnt[0] - e0), 1);
    check_eq("st_en_we", 64'(en_we[0]), 1);
    check_eq("st_wdata", en_wdata[0], 64'h0000_0000_DEAD_BEEF);
    check_eq("st_addr", en_addr[0], 64'h200);
    check_eq("st_d_rdata", d_rdata[0], 64'hC0DE_0000_0000_0120);
    check_eq("st_wdata_hold", mem_wdata[0], 64'h0000_0000_DEAD_BEEF);
    check_eq("st_we_idle", 64'(mem_we[0]), 0);

    // reset while waiting on memory
    if_req[0] = 1'b1; if_addr[0] = 64'h40;
    tick();
    tick();
    check_eq("ra_busy_pre", 64'(busy[0]), 1);
    reset = 1'b1; if_req[0] = 1'b0;
    tick();
    reset = 1'b0;
    check_eq("ra_busy", 64'(busy[0]), 0);
    check_eq("ra_if_rdata", if_rdata[0], 0);
    n0 = if_ack_cnt[0];
    repeat (20) tick();
    check_eq("ra_no_ack", 64'(if_ack_cnt[0] - n0), 0);
    run_txn(0, 1'b0, 1'b0, 64'h48, 64'h0, t, a);
    check_eq("ra_new_lat", 64'(a - t), 4);
    check_eq("ra_new_rdata", if_rdata[0], 64'hC0DE_0000_0000_0048);

    // latency extremes
    run_txn(1, 1'b0, 1'b0, 64'h40, 64'h0, t, a);
    check_eq("l1_ack_lat", 64'(a - t), 3);
    check_eq("l1_rdata", if_rdata[1], 64'h0000_0000_0050_0093);
    check_eq("l1_en_cnt", 64'(en_cnt[1]), 1);
    run_txn(2, 1'b0, 1'b0, 64'h44, 64'h0, t, a);
    check_eq("l15_ack_lat", 64'(a - t), 17);
    check_eq("l15_rdata", if_rdata[2], 64'hC0DE_0000_0000_0044);
    check_eq("l15_en_cnt", 64'(en_cnt[2]), 1);

    check_eq("en_width", 64'(wide_viol), 0);
    check_eq("we_qual", 64'(we_viol), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
